// File: rtl/mem_port_arbiter_pkg.sv
// mem_arb_pkg: state encoding and default sizes shared by the mem_port_arbiter slice
package mem_arb_pkg;
    typedef enum logic [1:0] {IDLE, ISSUE, CAPTURE} state_t;
    localparam int DEF_ADDR_W = 3;
    localparam int DEF_DATA_W = 3;
    localparam int DEF_MEM_DEPTH = 2;
    localparam int MAX_NUM_REQ = 4;
endpackage

// File: rtl/mem_port_arbiter_if.sv
// mem_port_arbiter_if: requester handshake and memory port bundle; slave is the arbiter side
interface mem_port_arbiter_if
    import mem_arb_pkg::*;
#(
    parameter int NUM_REQ = 2,
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W
);
    logic [NUM_REQ-1:0] req;
    logic [NUM_REQ-1:0] req_we;
    logic [NUM_REQ*ADDR_W-1:0] req_addr;
    logic [NUM_REQ*DATA_W-1:0] req_wdata;
    logic [NUM_REQ-1:0] gnt;
    logic [NUM_REQ-1:0] done;
    logic [DATA_W-1:0] rdata;
    logic err;
    logic busy;
    logic m_wr_en;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wr_data;
    logic [DATA_W-1:0] mem_rd_data;
    modport master (
        output req, req_we, req_addr, req_wdata, mem_rd_data,
        input gnt, done, rdata, err, busy, m_wr_en, mem_addr, mem_wr_data
    );
    modport slave (
        input req, req_we, req_addr, req_wdata, mem_rd_data,
        output gnt, done, rdata, err, busy, m_wr_en, mem_addr, mem_wr_data
    );
endinterface

// File: rtl/mem_port_arbiter_rr_picker.sv
// rr_picker: combinational round-robin winner, first set request after last_owner with wrap
module rr_picker #(
    parameter int NUM_REQ = 2,
    parameter int IW = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [IW-1:0]      last_owner_i,
    output logic [NUM_REQ-1:0] win_o,
    output logic               valid_o
);
    logic [NUM_REQ-1:0] mask;
    logic [NUM_REQ-1:0] hi;
    logic [NUM_REQ-1:0] pick;
    for (genvar g = 0; g < NUM_REQ; g++) begin : g_mask
        assign mask[g] = IW'(g) > last_owner_i;
    end
    assign hi = req_i & mask;
    assign pick = (|hi) ? hi : req_i;
    assign win_o = pick & (-pick);
    assign valid_o = |req_i;
endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: round-robin sequencer sharing one registered-read memory port; MEM_PORT_ARBITER_BOUNDS_CHECK_EN blocks out-of-range accesses
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int NUM_REQ = 2,
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W,
    parameter int MEM_DEPTH = DEF_MEM_DEPTH
) (
    input logic clk,
    input logic rst,
    mem_port_arbiter_if.slave bus
);
    localparam int IW = $clog2(NUM_REQ);
`ifdef MEM_PORT_ARBITER_BOUNDS_CHECK_EN
    localparam bit BOUNDS_EN = 1'b1;
`else
    localparam bit BOUNDS_EN = 1'b0;
`endif
    state_t state_q, state_d;
    logic [NUM_REQ-1:0] owner_q, owner_d, win;
    logic [IW-1:0] last_q, last_d, owner_idx;
    logic we_q, we_d, oob_q, oob_d, win_valid, sel_we, sel_oob;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d, sel_addr;
    logic [DATA_W-1:0] mem_wr_data_q, mem_wr_data_d, sel_wdata;
    logic [DATA_W-1:0] rdata_q, rdata_d, rdata_now;

    rr_picker #(.NUM_REQ(NUM_REQ), .IW(IW)) u_picker (
        .req_i(bus.req),
        .last_owner_i(last_q),
        .win_o(win),
        .valid_o(win_valid)
    );

    // Select the winner's fields and encode the current owner as an index
    always_comb begin
        sel_addr = '0;
        sel_wdata = '0;
        owner_idx = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (win[i]) begin
                sel_addr = bus.req_addr[i*ADDR_W +: ADDR_W];
                sel_wdata = bus.req_wdata[i*DATA_W +: DATA_W];
            end
            if (owner_q[i]) owner_idx = IW'(i);
        end
    end

    assign sel_we = |(bus.req_we & win);
    assign sel_oob = BOUNDS_EN && (32'(sel_addr) >= MEM_DEPTH);

    // Next state and latched access fields; blocked accesses keep the old address
    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        last_d = last_q;
        we_d = we_q;
        oob_d = oob_q;
        mem_addr_d = mem_addr_q;
        mem_wr_data_d = mem_wr_data_q;
        rdata_d = rdata_q;
        rdata_now = oob_q ? '0 : bus.mem_rd_data;
        case (state_q)
            IDLE: if (win_valid) begin
                state_d = ISSUE;
                owner_d = win;
                we_d = sel_we;
                oob_d = sel_oob;
                mem_addr_d = sel_oob ? mem_addr_q : sel_addr;
                mem_wr_data_d = sel_wdata;
            end
            ISSUE: state_d = CAPTURE;
            CAPTURE: begin
                state_d = IDLE;
                rdata_d = rdata_now;
                last_d = owner_idx;
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.gnt = (state_q != IDLE) ? owner_q : '0;
    assign bus.done = (state_q == CAPTURE) ? owner_q : '0;
    assign bus.rdata = (state_q == CAPTURE) ? rdata_now : rdata_q;
    assign bus.err = (state_q == CAPTURE) && oob_q;
    assign bus.busy = state_q != IDLE;
    assign bus.m_wr_en = (state_q == ISSUE) && we_q && !oob_q;
    assign bus.mem_addr = mem_addr_q;
    assign bus.mem_wr_data = mem_wr_data_q;

    // State and access registers; requester 0 wins first after reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            owner_q <= '0;
            last_q <= IW'(NUM_REQ - 1);
            we_q <= 1'b0;
            oob_q <= 1'b0;
            mem_addr_q <= '0;
            mem_wr_data_q <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            last_q <= last_d;
            we_q <= we_d;
            oob_q <= oob_d;
            mem_addr_q <= mem_addr_d;
            mem_wr_data_q <= mem_wr_data_d;
            rdata_q <= rdata_d;
        end
    end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed scoreboard bench for mem_port_arbiter with a registered-read memory model
module tb_mem_port_arbiter;
`ifdef MEM_PORT_ARBITER_BOUNDS_CHECK_EN
    localparam bit BC = 1'b1;
`else
    localparam bit BC = 1'b0;
`endif
    typedef struct {
        int owner;
        logic [2:0] data;
        logic err;
    } exp_t;

    logic clk;
    logic rst;
    int tests = 0;
    int fails = 0;
    int cycle = 0;
    int last_done = 0;
    int prev_done;
    exp_t sb[$];
    logic [2:0] mem [8] = '{default: '0};
    logic [2:0] model [8] = '{default: '0};
    logic [2:0] rd_q = '0;

    mem_port_arbiter_if #(.NUM_REQ(2), .ADDR_W(3), .DATA_W(3)) bus ();

    mem_port_arbiter #(.NUM_REQ(2), .ADDR_W(3), .DATA_W(3), .MEM_DEPTH(2)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus.slave)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) begin
        if (bus.m_wr_en) mem[bus.mem_addr] <= bus.mem_wr_data;
        rd_q <= mem[bus.mem_addr];
    end
    assign bus.mem_rd_data = rd_q;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
        cycle++;
    endtask

    task automatic set_req(input int r, input bit we, input int addr, input int wdata);
        bus.req_we[r] = we;
        bus.req_addr[r*3 +: 3] = 3'(addr);
        bus.req_wdata[r*3 +: 3] = 3'(wdata);
        bus.req[r] = 1'b1;
    endtask

    task automatic push_exp(input int r, input bit we, input int addr, input int wdata);
        exp_t e;
        e.owner = r;
        e.err = BC && (addr >= 2);
        e.data = e.err ? 3'd0 : model[addr];
        if (we && !e.err) model[addr] = 3'(wdata);
        sb.push_back(e);
    endtask

    task automatic wait_done(input bit drop);
        exp_t e;
        int n;
        n = 0;
        do begin
            cyc();
            n++;
        end while (bus.done === 2'b00 && n < 10);
        chk("done_seen", 32'(|bus.done), 1);
        if (bus.done === 2'b00) return;
        if (sb.size() == 0) begin
            chk("sb_nonempty", 0, 1);
            return;
        end
        e = sb.pop_front();
        chk("done_owner", bus.done, 1 << e.owner);
        chk("rdata", bus.rdata, e.data);
        chk("err", bus.err, e.err);
        if (drop) bus.req[e.owner] = 1'b0;
        last_done = cycle;
    endtask

    initial begin
        rst = 1'b1;
        bus.req = '0;
        bus.req_we = '0;
        bus.req_addr = '0;
        bus.req_wdata = '0;
        cyc();
        cyc();
        chk("rst_gnt", bus.gnt, 0);
        chk("rst_done", bus.done, 0);
        chk("rst_busy", bus.busy, 0);
        chk("rst_err", bus.err, 0);
        chk("rst_wr_en", bus.m_wr_en, 0);
        chk("rst_addr", bus.mem_addr, 0);
        chk("rst_wdata", bus.mem_wr_data, 0);
        chk("rst_rdata", bus.rdata, 0);

        set_req(0, 0, 0, 0);
        set_req(1, 0, 1, 0);
        for (int k = 0; k < 4; k++) push_exp(k % 2, 0, k % 2, 0);
        rst = 1'b0;
        cyc();
        chk("cont_first_gnt", bus.gnt, 2'b01);
        wait_done(0);
        for (int k = 1; k < 4; k++) begin
            prev_done = last_done;
            wait_done(0);
            chk("cont_spacing", last_done - prev_done, 3);
        end
        bus.req = '0;
        cyc();

        set_req(0, 1, 1, 5);
        push_exp(0, 1, 1, 5);
        cyc();
        chk("wr_issue_en", bus.m_wr_en, 1);
        chk("wr_issue_addr", bus.mem_addr, 1);
        chk("wr_issue_data", bus.mem_wr_data, 5);
        chk("wr_issue_gnt", bus.gnt, 2'b01);
        chk("wr_issue_busy", bus.busy, 1);
        chk("wr_issue_done", bus.done, 0);
        wait_done(1);
        chk("wr_capture_en", bus.m_wr_en, 0);
        cyc();
        chk("idle_busy", bus.busy, 0);
        set_req(0, 0, 1, 0);
        push_exp(0, 0, 1, 0);
        wait_done(1);
        cyc();
        chk("rdata_hold", bus.rdata, 5);

        set_req(1, 1, 0, 3);
        push_exp(1, 1, 0, 3);
        wait_done(1);
        cyc();
        set_req(0, 0, 1, 0);
        set_req(1, 0, 0, 0);
        push_exp(0, 0, 1, 0);
        push_exp(1, 0, 0, 0);
        wait_done(1);
        wait_done(1);
        cyc();

        set_req(1, 0, 0, 0);
        push_exp(1, 0, 0, 0);
        cyc();
        chk("chg_gnt", bus.gnt, 2'b10);
        bus.req_addr[3 +: 3] = 3'd1;
        #1;
        chk("chg_addr_latched", bus.mem_addr, 0);
        wait_done(1);
        cyc();

        set_req(0, 0, 1, 0);
        cyc();
        cyc();
        chk("pre_rst_done", bus.done, 2'b01);
        rst = 1'b1;
        bus.req = '0;
        cyc();
        chk("mid_rst_done", bus.done, 0);
        chk("mid_rst_busy", bus.busy, 0);
        chk("mid_rst_gnt", bus.gnt, 0);
        chk("mid_rst_rdata", bus.rdata, 0);
        rst = 1'b0;
        cyc();
        chk("post_rst_busy", bus.busy, 0);
        set_req(1, 0, 0, 0);
        push_exp(1, 0, 0, 0);
        wait_done(1);
        cyc();

        set_req(0, 1, 6, 7);
        push_exp(0, 1, 6, 7);
        cyc();
        chk("oob_wr_en", bus.m_wr_en, !BC);
        chk("oob_addr", bus.mem_addr, BC ? 0 : 6);
        wait_done(1);
        cyc();
        chk("oob_idle_err", bus.err, 0);
        set_req(0, 0, 6, 0);
        push_exp(0, 0, 6, 0);
        wait_done(1);
        cyc();
        chk("sb_drained", sb.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Round-robin arbiter and sequencer that shares the single-port register-file memory (registered read, write-enable, shared address) between NUM_REQ requesters.
- Sits between the datapath clients and the memory.
- Latches one request, drives the memory for exactly one cycle, and returns read data with a done pulse.
- Every access is a read; a write access also returns the pre-write contents.

Parameters:
- NUM_REQ, 2, number of requesters (2..4)
- ADDR_W, 3, address width
- DATA_W, 3, data width
- MEM_DEPTH, 2, number of implemented memory entries

Ports:
- clk  in  1  clock, all logic on posedge
- rst  in  1  synchronous, active-high reset
- req  in  NUM_REQ  per-requester request level
- req_we  in  NUM_REQ  per-requester write flag
- req_addr  in  NUM_REQ*ADDR_W  packed addresses, requester i at [i*ADDR_W +: ADDR_W]
- req_wdata  in  NUM_REQ*DATA_W  packed write data
- gnt  out  NUM_REQ  one-hot grant, held from ISSUE through CAPTURE
- done  out  NUM_REQ  one-hot completion, high only in CAPTURE
- rdata  out  DATA_W  read result; valid while done is high
- err  out  1  address-fault flag (see Optional Feature)
- busy  out  1  high when state is not IDLE
- m_wr_en  out  1  memory write enable
- mem_addr  out  ADDR_W  memory address
- mem_wr_data  out  DATA_W  memory write data
- mem_rd_data  in  DATA_W  memory registered read data

Behaviour:
- Reset values:
  - gnt, done, err, busy, m_wr_en = 0.
  - mem_addr, mem_wr_data = 0; rdata register = 0.
  - State = IDLE; last_owner = NUM_REQ-1, so requester 0 wins first.
- FSM states: IDLE, ISSUE, CAPTURE.
- IDLE:
  - If any req bit is set, pick the winner by round-robin: the first set bit after last_owner, wrapping.
  - On the edge, latch the owner plus that owner's we/addr/wdata into mem_addr/mem_wr_data, set gnt[owner], and go to ISSUE.
  - If no req bit is set, stay in IDLE.
- ISSUE (exactly 1 cycle):
  - m_wr_en = latched we; gnt held.
  - The memory samples address and data on the closing edge.
  - Go to CAPTURE.
- CAPTURE (exactly 1 cycle):
  - m_wr_en = 0; done[owner] = 1.
  - rdata = mem_rd_data, passed through combinationally.
  - On the closing edge: rdata register <= mem_rd_data, last_owner <= owner, gnt cleared, go to IDLE.
- Outside CAPTURE, rdata shows the last captured value.
- Latency: req seen in IDLE at cycle 0 gives ISSUE at cycle 1 and done at cycle 2. Minimum spacing is 3 cycles per access.
- Handshake:
  - A requester holds req and its fields until it samples done.
  - It must drop req (or present the next request) on the done edge.
  - Fields are latched at grant; later changes are ignored for that access.
- Read-during-write: rdata returns the old contents of the written entry. The new value is visible on the next access.
- Simultaneous requests: round-robin guarantees no requester waits more than NUM_REQ-1 accesses.
- A req deasserted before grant is simply not served; no error.
- Reset mid-operation:
  - rst in ISSUE or CAPTURE returns to IDLE with all outputs at reset values.
  - No done is issued.
  - A write whose ISSUE edge coincides with rst still lands, because the memory has no reset.

Optional Feature:
- Macro: MEM_PORT_ARBITER_BOUNDS_CHECK_EN.
- When defined:
  - A latched address >= MEM_DEPTH is not issued: m_wr_en stays 0 and mem_addr is left unchanged.
  - The FSM still runs ISSUE then CAPTURE.
  - In CAPTURE, done and err are both 1 and rdata = 0.
- When undefined:
  - err is tied 0.
  - Addresses are forwarded unchanged; out-of-range behaviour belongs to the memory.

Decomposition:
- Package mem_arb_pkg holds:
  - the state enum (IDLE, ISSUE, CAPTURE);
  - default ADDR_W, DATA_W and MEM_DEPTH constants;
  - the NUM_REQ maximum.
- One combinational sub-module, rr_picker: inputs req and last_owner; outputs a one-hot winner and a valid flag.
- FSM and registers stay in the top level.

Test Plan:
- Single write then read: r0 writes addr 1 with data 3'b101 → m_wr_en high for 1 cycle at cycle 1, done[0] at cycle 2 with the old data. Next r0 read of addr 1 → rdata = 3'b101.
- Contention: r0 and r1 request continuously from reset → grants alternate 0,1,0,1. done pulses every 3 cycles and are never both set.
- Fairness after idle: r1 served alone, then both request → r0 wins next.
- Field change after grant: r1 changes req_addr during ISSUE → mem_addr keeps the latched value; data returned is from the original address.
- Reset mid-access: assert rst during CAPTURE → done not seen after reset; busy = 0, gnt = 0, state IDLE next cycle. A fresh request then completes normally.
- Bounds (macro defined): read addr 3'b110 → m_wr_en stays 0, err = 1 and done = 1 at cycle 2, rdata = 0. Macro undefined: err stays 0.
